// File: rtl/sparse_link_controller.sv
// sparse_link_controller: checksummed (value,index) packet deframer/framer
// between a UART byte link and parallel sparse-row buses.
module sparse_link_controller #(
  parameter int MAX_NNZ   = 8,
  parameter int VAL_BYTES = 2,
  parameter int IDX_BYTES = 2,
  parameter int TIMEOUT   = 1024,
  parameter int NW = $clog2(MAX_NNZ+1),
  parameter int VW = 8*VAL_BYTES,
  parameter int IW = 8*IDX_BYTES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_byte,
  output logic                  rx_valid,
  output logic [NW-1:0]         rx_nnz,
  output logic [MAX_NNZ*VW-1:0] rx_values,
  output logic [MAX_NNZ*IW-1:0] rx_indices,
  output logic                  rx_err,
  output logic [1:0]            rx_err_code,
  input  logic                  tx_req,
  input  logic [NW-1:0]         tx_nnz,
  input  logic [MAX_NNZ*VW-1:0] tx_values,
  input  logic [MAX_NNZ*IW-1:0] tx_indices,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_err
);
  localparam int MB = (VAL_BYTES > IDX_BYTES) ? VAL_BYTES : IDX_BYTES;
  localparam int CW = $clog2(MAX_NNZ*MB+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int PW = $clog2(2+MAX_NNZ*(VAL_BYTES+IDX_BYTES));

  localparam logic [CW-1:0] VB   = CW'(VAL_BYTES);
  localparam logic [CW-1:0] IB   = CW'(IDX_BYTES);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T1   = TW'(1);
  localparam logic [7:0]    NMAX = 8'(MAX_NNZ);
  localparam logic [NW-1:0] NLIM = NW'(MAX_NNZ);
  localparam logic [PW-1:0] PB   = PW'(VAL_BYTES+IDX_BYTES);
  localparam logic [PW-1:0] PV   = PW'(VAL_BYTES);
  localparam logic [PW-1:0] P1   = PW'(1);

  typedef enum logic [2:0] {
    R_IDLE, R_VAL, R_IDX, R_SUM, R_DRAIN
  } r_state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_SEND, T_WAIT, T_DONE
  } t_state_t;

  r_state_t      r_state, r_next;
  logic [NW-1:0] r_n;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_sum;
  logic [VW-1:0] sh_val [MAX_NNZ];
  logic [IW-1:0] sh_idx [MAX_NNZ];
  logic          r_tmo, r_acc, r_ok, r_bad;
  logic [1:0]    r_code;
  logic [CW-1:0] r_vlen, r_ilen, r_ve, r_ie;

  assign r_tmo  = (r_state != R_IDLE) && (r_tcnt == TMO);
  assign r_acc  = rx_ready && !r_tmo;
  assign r_vlen = CW'(r_n) * VB;
  assign r_ilen = CW'(r_n) * IB;
  assign r_ve   = r_cnt / VB;
  assign r_ie   = r_cnt / IB;

  // timeout has priority over a byte arriving in the same cycle
  always_comb begin
    r_next = r_state;
    r_ok   = 1'b0;
    r_bad  = 1'b0;
    r_code = 2'd3;
    if (r_tmo) begin
      r_next = R_IDLE;
      r_bad  = (r_state != R_DRAIN);
    end else if (rx_ready) begin
      unique case (r_state)
        R_IDLE: begin
          if (rx_byte == 8'd0 || rx_byte > NMAX) begin
            r_next = R_DRAIN;
            r_bad  = 1'b1;
            r_code = 2'd1;
          end else begin
            r_next = R_VAL;
          end
        end
        R_VAL: if (r_cnt + C1 == r_vlen) r_next = R_IDX;
        R_IDX: if (r_cnt + C1 == r_ilen) r_next = R_SUM;
        R_SUM: begin
          r_next = R_IDLE;
          r_ok   = (rx_byte == r_sum);
          r_bad  = (rx_byte != r_sum);
          r_code = 2'd2;
        end
        R_DRAIN: r_next = R_DRAIN;
        default: r_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= R_IDLE;
      r_n         <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      r_sum       <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= 2'd0;
      rx_nnz      <= '0;
      rx_values   <= '0;
      rx_indices  <= '0;
      for (int k = 0; k < MAX_NNZ; k++) begin
        sh_val[k] <= '0;
        sh_idx[k] <= '0;
      end
    end else begin
      r_state  <= r_next;
      rx_valid <= r_ok;
      rx_err   <= r_bad;
      if (r_bad) rx_err_code <= r_code;
      if (r_state == R_IDLE || rx_ready || r_tmo)
        r_tcnt <= '0;
      else
        r_tcnt <= r_tcnt + T1;
      if (r_acc) begin
        unique case (r_state)
          R_IDLE: begin
            if (r_next == R_VAL) begin
              r_n   <= NW'(rx_byte);
              r_sum <= rx_byte;
              r_cnt <= '0;
              for (int k = 0; k < MAX_NNZ; k++) begin
                sh_val[k] <= '0;
                sh_idx[k] <= '0;
              end
            end
          end
          R_VAL, R_IDX: begin
            r_sum <= r_sum ^ rx_byte;
            r_cnt <= (r_next != r_state) ? '0 : r_cnt + C1;
            for (int k = 0; k < MAX_NNZ; k++) begin
              if (r_state == R_VAL && CW'(k) == r_ve)
                sh_val[k] <= (sh_val[k] << 8) | VW'(rx_byte);
              if (r_state == R_IDX && CW'(k) == r_ie)
                sh_idx[k] <= (sh_idx[k] << 8) | IW'(rx_byte);
            end
          end
          R_SUM: begin
            if (r_ok) begin
              rx_nnz <= r_n;
              for (int k = 0; k < MAX_NNZ; k++) begin
                rx_values[k*VW +: VW]  <= sh_val[k];
                rx_indices[k*IW +: IW] <= sh_idx[k];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  t_state_t              t_state, t_next;
  logic [NW-1:0]         t_n;
  logic [MAX_NNZ*VW-1:0] t_vals;
  logic [MAX_NNZ*IW-1:0] t_idxs;
  logic [PW-1:0]         t_pos, t_last, t_ioff;
  logic [7:0]            t_sum, t_nx;
  logic                  t_nnz_ok;

  assign t_nnz_ok = (tx_nnz != '0) && (tx_nnz <= NLIM);
  assign t_last   = PW'(t_n) * PB + P1;
  assign t_ioff   = PW'(t_n) * PV + P1;

  // byte at stream position t_pos; checksum is the fallback
  always_comb begin
    t_nx = t_sum;
    if (t_pos == '0) t_nx = 8'(t_n);
    for (int k = 0; k < MAX_NNZ; k++) begin
      for (int b = 0; b < VAL_BYTES; b++)
        if (NW'(k) < t_n &&
            t_pos == PW'(1 + k*VAL_BYTES + b))
          t_nx = t_vals[k*VW + (VAL_BYTES-1-b)*8 +: 8];
      for (int b = 0; b < IDX_BYTES; b++)
        if (NW'(k) < t_n &&
            t_pos == t_ioff + PW'(k*IDX_BYTES + b))
          t_nx = t_idxs[k*IW + (IDX_BYTES-1-b)*8 +: 8];
    end
  end

  always_comb begin
    t_next = t_state;
    unique case (t_state)
      T_IDLE: if (tx_req && t_nnz_ok) t_next = T_SEND;
      T_SEND: if (tx_ready) t_next = T_WAIT;
      T_WAIT: begin
        if (!tx_ready)
          t_next = (t_pos == t_last) ? T_DONE : T_SEND;
      end
      T_DONE: if (tx_ready) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t_state  <= T_IDLE;
      t_n      <= '0;
      t_vals   <= '0;
      t_idxs   <= '0;
      t_pos    <= '0;
      t_sum    <= '0;
      tx_start <= 1'b0;
      tx_byte  <= '0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      t_state  <= t_next;
      tx_start <= (t_state == T_SEND) && tx_ready;
      tx_done  <= (t_state == T_DONE) && tx_ready;
      tx_err   <= (t_state == T_IDLE) && tx_req && !t_nnz_ok;
      unique case (t_state)
        T_IDLE: begin
          if (tx_req && t_nnz_ok) begin
            t_n     <= tx_nnz;
            t_vals  <= tx_values;
            t_idxs  <= tx_indices;
            t_pos   <= '0;
            t_sum   <= '0;
            tx_busy <= 1'b1;
          end
        end
        T_SEND: begin
          if (tx_ready) begin
            tx_byte <= t_nx;
            t_sum   <= t_sum ^ t_nx;
          end
        end
        T_WAIT: begin
          if (!tx_ready && t_pos != t_last)
            t_pos <= t_pos + P1;
        end
        T_DONE: if (tx_ready) tx_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_link_controller.sv
// Directed bench for sparse_link_controller: RX framing/errors,
// TX serialisation against a slow UART model, and mid-packet reset.
module tb_sparse_link_controller;
  localparam int TIMEOUT = 1024;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rx_ready, rx_valid, rx_err;
  logic [7:0]   rx_byte;
  logic [3:0]   rx_nnz, tx_nnz;
  logic [127:0] rx_values, rx_indices, tx_values, tx_indices;
  logic [1:0]   rx_err_code;
  logic         tx_req, tx_ready, tx_start, tx_busy, tx_done, tx_err;
  logic [7:0]   tx_byte;

  sparse_link_controller #(
    .MAX_NNZ(8), .VAL_BYTES(2), .IDX_BYTES(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rx_ready(rx_ready), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_nnz(rx_nnz),
    .rx_values(rx_values), .rx_indices(rx_indices),
    .rx_err(rx_err), .rx_err_code(rx_err_code),
    .tx_req(tx_req), .tx_nnz(tx_nnz),
    .tx_values(tx_values), .tx_indices(tx_indices),
    .tx_ready(tx_ready), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] VA  = {96'h0, 16'h00FF, 16'h1234};
  localparam logic [127:0] IA  = {96'h0, 16'h0007, 16'h0003};
  localparam logic [127:0] VB1 = {112'h0, 16'hABCD};
  localparam logic [127:0] IB1 = {112'h0, 16'h1234};
  localparam logic [127:0] SA  = {48'h0, 80'h02123400FF00030007DF};

  int n_chk = 0, n_pass = 0;
  int n_valid = 0, n_err = 0, n_start = 0;
  int v0, e0, s0;
  logic post_valid, post_err;
  logic [7:0] txq[$];
  logic [7:0] pa[$], pbad[$], pb[$], plen[$], ptmo[$], phalf[$];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) begin
      rx_byte  = q[i];
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready   = 1'b0;
      post_valid = rx_valid;
      post_err   = rx_err;
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] pack_q();
    logic [127:0] r = '0;
    foreach (txq[i]) r = {r[119:0], txq[i]};
    return r;
  endfunction

  task automatic tx_send(input logic [3:0] n);
    tx_nnz = n;
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_done) break;
    end
    chk({tag, "_done"}, 128'(tx_done), 128'd1);
    chk({tag, "_busy_fall"}, 128'(tx_busy), 128'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) n_valid++;
      if (rx_err) n_err++;
    end
  end

  // UART transmitter: busy for 10 cycles after each launch
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_start++;
        txq.push_back(tx_byte);
        tx_ready = 1'b0;
        repeat (10) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  initial begin
    rx_ready = 1'b0; rx_byte = '0;
    tx_req = 1'b0; tx_nnz = '0;
    tx_values = VA; tx_indices = IA;
    pa    = '{8'h02, 8'h12, 8'h34, 8'h00, 8'hFF,
              8'h00, 8'h03, 8'h00, 8'h07, 8'hDF};
    pbad  = '{8'h02, 8'h12, 8'h34, 8'h00, 8'hFF,
              8'h00, 8'h03, 8'h00, 8'h07, 8'hDE};
    pb    = '{8'h01, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h41};
    plen  = '{8'h09, 8'h01, 8'h02, 8'h03};
    ptmo  = '{8'h02, 8'h12};
    phalf = '{8'h02, 8'h12, 8'h34, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_rx_valid", 128'(rx_valid), 128'd0);
    chk("rst_rx_nnz", 128'(rx_nnz), 128'd0);
    chk("rst_rx_values", rx_values, 128'd0);
    chk("rst_rx_err", 128'({rx_err, rx_err_code}), 128'd0);
    chk("rst_tx", 128'({tx_start, tx_byte, tx_busy, tx_done, tx_err}),
        128'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    v0 = n_valid; e0 = n_err;
    send_bytes(pa);
    chk("good_valid_timing", 128'(post_valid), 128'd1);
    repeat (3) @(negedge clk);
    chk("good_valid_once", 128'(n_valid - v0), 128'd1);
    chk("good_no_err", 128'(n_err - e0), 128'd0);
    chk("good_nnz", 128'(rx_nnz), 128'd2);
    chk("good_values", rx_values, VA);
    chk("good_indices", rx_indices, IA);

    v0 = n_valid; e0 = n_err;
    send_bytes(pbad);
    chk("sum_err_timing", 128'(post_err), 128'd1);
    repeat (3) @(negedge clk);
    chk("sum_err_once", 128'(n_err - e0), 128'd1);
    chk("sum_code", 128'(rx_err_code), 128'd2);
    chk("sum_no_valid", 128'(n_valid - v0), 128'd0);
    chk("sum_held_values", rx_values, VA);
    chk("sum_held_nnz", 128'(rx_nnz), 128'd2);

    v0 = n_valid;
    send_bytes(pb);
    repeat (3) @(negedge clk);
    chk("pb_valid", 128'(n_valid - v0), 128'd1);
    chk("pb_nnz", 128'(rx_nnz), 128'd1);
    chk("pb_values", rx_values, VB1);
    chk("pb_indices", rx_indices, IB1);

    v0 = n_valid; e0 = n_err;
    send_bytes(plen);
    repeat (3) @(negedge clk);
    chk("len_code", 128'(rx_err_code), 128'd1);
    repeat (TIMEOUT + 10) @(negedge clk);
    chk("len_err_once", 128'(n_err - e0), 128'd1);
    chk("len_no_valid", 128'(n_valid - v0), 128'd0);
    send_bytes(pa);
    repeat (3) @(negedge clk);
    chk("len_next_valid", 128'(n_valid - v0), 128'd1);
    chk("len_next_values", rx_values, VA);

    v0 = n_valid; e0 = n_err;
    send_bytes(ptmo);
    repeat (TIMEOUT + 10) @(negedge clk);
    chk("tmo_err_once", 128'(n_err - e0), 128'd1);
    chk("tmo_code", 128'(rx_err_code), 128'd3);
    send_bytes(pb);
    repeat (3) @(negedge clk);
    chk("tmo_next_valid", 128'(n_valid - v0), 128'd1);
    chk("tmo_next_values", rx_values, VB1);
    chk("tmo_code_held", 128'(rx_err_code), 128'd3);

    txq.delete(); s0 = n_start;
    tx_send(4'd2);
    chk("tx_busy_rise", 128'(tx_busy), 128'd1);
    repeat (3) @(negedge clk);
    tx_send(4'd1);
    wait_done("tx1");
    repeat (200) @(negedge clk);
    chk("tx1_starts", 128'(n_start - s0), 128'd10);
    chk("tx1_bytes", pack_q(), SA);
    chk("tx1_idle", 128'(tx_busy), 128'd0);

    s0 = n_start;
    tx_send(4'd0);
    chk("txerr_pulse", 128'(tx_err), 128'd1);
    repeat (30) @(negedge clk);
    chk("txerr_no_send", 128'({n_start - s0, tx_busy}), 128'd0);

    send_bytes(phalf);
    txq.delete(); s0 = n_start;
    tx_send(4'd2);
    for (int i = 0; i < 500 && (n_start - s0) < 3; i++)
      @(negedge clk);
    chk("mid_tx_started", 128'(n_start - s0), 128'd3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_rx", 128'({rx_valid, rx_err, rx_err_code, rx_nnz}),
        128'd0);
    chk("mid_rst_vals", rx_values | rx_indices, 128'd0);
    chk("mid_rst_tx", 128'({tx_start, tx_byte, tx_busy, tx_done, tx_err}),
        128'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (15) @(negedge clk);

    v0 = n_valid;
    send_bytes(pa);
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 128'(n_valid - v0), 128'd1);
    chk("post_rst_values", rx_values, VA);
    chk("post_rst_indices", rx_indices, IA);

    txq.delete(); s0 = n_start;
    tx_send(4'd2);
    wait_done("tx2");
    repeat (5) @(negedge clk);
    chk("tx2_starts", 128'(n_start - s0), 128'd10);
    chk("tx2_bytes", pack_q(), SA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
